// File: rtl/clock_set_controller.sv
// clock_set_controller
//   Front-panel sequencer for the world clock. Conditions the three set-mode
//   buttons, runs the RUN/SET state machine and emits one-cycle increment
//   pulses, with auto-repeat, to the hour/minute/day/month/year counters.
//   It also drives the display view select, the field blink and the
//   timekeeping run enable.
//
//   Optional feature: define AUTO_CYCLE_EN to let the view toggle between
//   time and date on its own every AUTO_CYCLE_CYC cycles while in RUN.
//
// Ports
//   clk100hz   in   100 Hz system clock
//   reset      in   asynchronous, active-high
//   btn_mode   in   raw button: enter / leave set mode
//   btn_next   in   raw button: advance to the next field
//   btn_inc    in   raw button: increment field (in RUN: toggle the view)
//   inc_hour .. inc_year  out  registered one-cycle increment pulses
//   field_sel  out  [2:0] 0=RUN 1=HOUR 2=MIN 3=DAY 4=MONTH 5=YEAR
//   view_date  out  0 = time view, 1 = date view
//   blank      out  blank the digits of the selected field
//   run_en     out  timekeeping counters may advance

// Per-button conditioning: 2-flop synchronizer plus a consecutive-mismatch
// debounce counter. press is a one-cycle rising-edge event of the level.
module clock_set_debounce #(
    parameter int DEBOUNCE_CYC = 3
) (
    input  logic clk100hz,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          mismatch;
    logic          flip;

    // The level flips on the sample that mismatches after DEBOUNCE_CYC
    // mismatches have already been counted. A pulse must therefore survive
    // DEBOUNCE_CYC+1 samples, and press is asserted in the cycle before the
    // level register flips so that downstream registers land on the same
    // edge as the level.
    assign mismatch = sync[1] ^ level;
    assign flip     = mismatch && (cnt == CW'(DEBOUNCE_CYC));
    assign press    = flip && !level;

    always_ff @(posedge clk100hz or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (!mismatch || flip)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (flip)
                level <= ~level;
        end
    end
endmodule

module clock_set_controller #(
    parameter int DEBOUNCE_CYC   = 3,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10,
    parameter int TIMEOUT_CYC    = 1000,
    parameter int BLINK_HALF     = 25,
    parameter int AUTO_CYCLE_CYC = 500
) (
    input  logic       clk100hz,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       inc_day,
    output logic       inc_month,
    output logic       inc_year,
    output logic [2:0] field_sel,
    output logic       view_date,
    output logic       blank,
    output logic       run_en
);
    localparam int NUM_BTN = 3;
    localparam int B_MODE  = 0;
    localparam int B_NEXT  = 1;
    localparam int B_INC   = 2;

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT_CYC);
    localparam int BW      = $clog2(2 * BLINK_HALF);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_HOUR  = 3'd1,
        ST_MIN   = 3'd2,
        ST_DAY   = 3'd3,
        ST_MONTH = 3'd4,
        ST_YEAR  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_lvl;
    logic [NUM_BTN-1:0] btn_press;

    assign btn_raw = {btn_inc, btn_next, btn_mode};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        clock_set_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .clk100hz(clk100hz),
            .reset   (reset),
            .raw     (btn_raw[i]),
            .level   (btn_lvl[i]),
            .press   (btn_press[i])
        );
    end

    logic mode_p, next_p, inc_p, inc_lvl;
    assign mode_p  = btn_press[B_MODE];
    assign next_p  = btn_press[B_NEXT];
    assign inc_p   = btn_press[B_INC];
    assign inc_lvl = btn_lvl[B_INC];

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    state_t        state, state_nxt;
    logic [RW-1:0] rpt_cnt;
    logic          rpt_arm;
    logic          rpt_phase;     // 0: waiting out REPEAT_DELAY, 1: REPEAT_RATE
    logic [TW-1:0] tmo_cnt;
    logic [BW-1:0] blink_cnt;
    logic [4:0]    inc_vec, inc_nxt;
    logic          view_nxt;

    logic inc_acc;     // inc press that survives mode > next > inc priority
    logic state_chg;
    logic in_set;
    logic idle;
    logic timeout;
    logic rpt_fire;
    logic fire;
    logic auto_tgl;

    assign in_set  = (state != ST_RUN);
    assign inc_acc = inc_p && !mode_p && !next_p;
    assign idle    = !(|btn_lvl) && !(|btn_press);
    assign timeout = in_set && idle && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt = state;
        if (!in_set) begin
            if (mode_p)
                state_nxt = ST_HOUR;
        end else if (mode_p) begin
            state_nxt = ST_RUN;
        end else if (next_p) begin
            case (state)
                ST_HOUR:  state_nxt = ST_MIN;
                ST_MIN:   state_nxt = ST_DAY;
                ST_DAY:   state_nxt = ST_MONTH;
                ST_MONTH: state_nxt = ST_YEAR;
                default:  state_nxt = ST_RUN;
            endcase
        end else if (timeout) begin
            state_nxt = ST_RUN;
        end
    end

    assign state_chg = (state_nxt != state);

    assign rpt_fire = rpt_arm && inc_lvl &&
                      (rpt_phase ? (rpt_cnt == RW'(REPEAT_RATE))
                                 : (rpt_cnt == RW'(REPEAT_DELAY)));

    // A state change in the same cycle swallows both the press and any
    // pending repeat, so pulses never leak into the next field or RUN.
    assign fire = in_set && !state_chg && (inc_acc || rpt_fire);

    always_comb begin
        inc_nxt = '0;
        if (fire) begin
            case (state)
                ST_HOUR:  inc_nxt[0] = 1'b1;
                ST_MIN:   inc_nxt[1] = 1'b1;
                ST_DAY:   inc_nxt[2] = 1'b1;
                ST_MONTH: inc_nxt[3] = 1'b1;
                ST_YEAR:  inc_nxt[4] = 1'b1;
                default:  inc_nxt    = '0;
            endcase
        end
    end

    // Entering any state fixes the view; within RUN only a toggle moves it.
    always_comb begin
        view_nxt = view_date;
        if (state_chg)
            view_nxt = (state_nxt == ST_DAY) || (state_nxt == ST_MONTH) ||
                       (state_nxt == ST_YEAR);
        else if (!in_set && (inc_acc || auto_tgl))
            view_nxt = ~view_date;
    end

`ifdef AUTO_CYCLE_EN
    localparam int AW = $clog2(AUTO_CYCLE_CYC);
    logic [AW-1:0] ac_cnt;

    assign auto_tgl = !in_set && (ac_cnt == AW'(AUTO_CYCLE_CYC - 1));

    always_ff @(posedge clk100hz or posedge reset) begin
        if (reset)
            ac_cnt <= '0;
        else if (in_set || state_chg || inc_acc || auto_tgl)
            ac_cnt <= '0;
        else
            ac_cnt <= ac_cnt + AW'(1);
    end
`else
    assign auto_tgl = 1'b0;
`endif

    always_ff @(posedge clk100hz or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            view_date <= 1'b0;
            run_en    <= 1'b1;
            inc_vec   <= '0;
        end else begin
            state     <= state_nxt;
            view_date <= view_nxt;
            run_en    <= (state_nxt == ST_RUN);
            inc_vec   <= inc_nxt;
        end
    end

    // Auto-repeat: armed by an accepted press in a SET state. The count
    // includes the press cycle so the first repeat lands REPEAT_DELAY edges
    // after the press pulse, later ones every REPEAT_RATE edges.
    always_ff @(posedge clk100hz or posedge reset) begin
        if (reset) begin
            rpt_arm   <= 1'b0;
            rpt_phase <= 1'b0;
            rpt_cnt   <= '0;
        end else if (in_set && !state_chg && inc_acc) begin
            rpt_arm   <= 1'b1;
            rpt_phase <= 1'b0;
            rpt_cnt   <= RW'(1);
        end else if (state_chg || !inc_lvl || !rpt_arm) begin
            rpt_arm   <= 1'b0;
            rpt_phase <= 1'b0;
            rpt_cnt   <= '0;
        end else if (rpt_fire) begin
            rpt_phase <= 1'b1;
            rpt_cnt   <= RW'(1);
        end else begin
            rpt_cnt   <= rpt_cnt + RW'(1);
        end
    end

    // Idle timer: only counts while nothing is pressed or held.
    always_ff @(posedge clk100hz or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (!in_set || state_chg || !idle)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    always_ff @(posedge clk100hz or posedge reset) begin
        if (reset)
            blink_cnt <= '0;
        else if (!in_set || state_chg || (blink_cnt == BW'(2 * BLINK_HALF - 1)))
            blink_cnt <= '0;
        else
            blink_cnt <= blink_cnt + BW'(1);
    end

    // Holding inc keeps the digits lit so the user can watch them move.
    assign blank = in_set && !inc_lvl && (blink_cnt >= BW'(BLINK_HALF));

    assign field_sel = state;
    assign inc_hour  = inc_vec[0];
    assign inc_min   = inc_vec[1];
    assign inc_day   = inc_vec[2];
    assign inc_month = inc_vec[3];
    assign inc_year  = inc_vec[4];
endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller. Inputs change and outputs are
// sampled 1 time unit after the falling edge; pulse counters run on the
// falling edge itself so they are settled when a task reads them.
module tb_clock_set_controller;
    logic       clk100hz = 1'b0;
    logic       reset;
    logic       btn_mode, btn_next, btn_inc;
    logic       inc_hour, inc_min, inc_day, inc_month, inc_year;
    logic [2:0] field_sel;
    logic       view_date, blank, run_en;

    int n_checks = 0;
    int n_fails  = 0;
    int n_hour = 0, n_min = 0, n_day = 0, n_month = 0, n_year = 0;

    always #5 clk100hz = ~clk100hz;

    clock_set_controller dut (
        .clk100hz (clk100hz),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_next (btn_next),
        .btn_inc  (btn_inc),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .inc_day  (inc_day),
        .inc_month(inc_month),
        .inc_year (inc_year),
        .field_sel(field_sel),
        .view_date(view_date),
        .blank    (blank),
        .run_en   (run_en)
    );

    always @(negedge clk100hz) begin
        if (inc_hour)  n_hour++;
        if (inc_min)   n_min++;
        if (inc_day)   n_day++;
        if (inc_month) n_month++;
        if (inc_year)  n_year++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk100hz);
            #1;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_mode = v;
            1:       btn_next = v;
            default: btn_inc  = v;
        endcase
    endtask

    // 4-cycle raw press, then wait until the debounced level has fallen.
    task automatic tap(input int b);
        set_btn(b, 1'b1);
        cyc(4);
        set_btn(b, 1'b0);
        cyc(8);
    endtask

    task automatic test_reset;
        reset = 1'b1; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
        cyc(2);
        n_checks++;
        if (field_sel !== 3'd0 || run_en !== 1'b1 || view_date !== 1'b0 || blank !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_state: field=%0d run_en=%b view=%b blank=%b, want 0 1 0 0",
                     field_sel, run_en, view_date, blank);
        end
        n_checks++;
        if ({inc_hour, inc_min, inc_day, inc_month, inc_year} !== 5'b0) begin
            n_fails++;
            $display("FAIL reset_inc: inc=%b want 00000",
                     {inc_hour, inc_min, inc_day, inc_month, inc_year});
        end
        reset = 1'b0;
        cyc(3);
        n_checks++;
        if (field_sel !== 3'd0 || run_en !== 1'b1) begin
            n_fails++;
            $display("FAIL post_reset: field=%0d run_en=%b want 0 1", field_sel, run_en);
        end
    endtask

    task automatic test_enter_set;
        btn_mode = 1'b1;
        cyc(4);
        btn_mode = 1'b0;
        cyc(1);                        // after edge 4
        n_checks++;
        if (field_sel !== 3'd0 || run_en !== 1'b1) begin
            n_fails++;
            $display("FAIL mode_early: field=%0d run_en=%b want 0 1", field_sel, run_en);
        end
        cyc(1);                        // after edge 5: entry into HOUR
        n_checks++;
        if (field_sel !== 3'd1 || run_en !== 1'b0 || view_date !== 1'b0) begin
            n_fails++;
            $display("FAIL mode_enter: field=%0d run_en=%b view=%b want 1 0 0",
                     field_sel, run_en, view_date);
        end
        for (int k = 0; k < 60; k++) begin
            if (k > 0) cyc(1);
            n_checks++;
            if (blank !== ((k % 50) >= 25)) begin
                n_fails++;
                $display("FAIL blink k=%0d: blank=%b want %b", k, blank, ((k % 50) >= 25));
            end
        end
    endtask

    task automatic test_debounce;
        int h0;
        h0 = n_hour;
        btn_inc = 1'b1;
        cyc(3);
        btn_inc = 1'b0;
        cyc(12);
        n_checks++;
        if (n_hour !== h0 || field_sel !== 3'd1) begin
            n_fails++;
            $display("FAIL short_pulse: hour pulses=%0d field=%0d want 0 1", n_hour - h0, field_sel);
        end
        btn_inc = 1'b1;
        cyc(4);
        btn_inc = 1'b0;
        cyc(1);                        // after edge 4
        n_checks++;
        if (inc_hour !== 1'b0) begin
            n_fails++;
            $display("FAIL press_edge4: inc_hour=%b want 0", inc_hour);
        end
        cyc(1);                        // after edge 5
        n_checks++;
        if (inc_hour !== 1'b1 || {inc_min, inc_day, inc_month, inc_year} !== 4'b0) begin
            n_fails++;
            $display("FAIL press_edge5: inc_hour=%b others=%b want 1 0000",
                     inc_hour, {inc_min, inc_day, inc_month, inc_year});
        end
        cyc(1);                        // after edge 6
        n_checks++;
        if (inc_hour !== 1'b0) begin
            n_fails++;
            $display("FAIL press_edge6: inc_hour=%b want 0", inc_hour);
        end
        cyc(8);
        n_checks++;
        if (n_hour - h0 !== 1) begin
            n_fails++;
            $display("FAIL press_count: hour pulses=%0d want 1", n_hour - h0);
        end
    endtask

    task automatic test_auto_repeat;
        int m0, o0, e;
        logic exp;
        tap(1);
        n_checks++;
        if (field_sel !== 3'd2) begin
            n_fails++;
            $display("FAIL enter_min: field=%0d want 2", field_sel);
        end
        m0 = n_min;
        o0 = n_hour + n_day + n_month + n_year;
        btn_inc = 1'b1;
        for (int t = 1; t <= 110; t++) begin
            cyc(1);
            e = t - 1;
            exp = (e == 5) || (e == 55) || (e == 65) || (e == 75) || (e == 85) || (e == 95);
            n_checks++;
            if (inc_min !== exp || {inc_hour, inc_day, inc_month, inc_year} !== 4'b0) begin
                n_fails++;
                $display("FAIL repeat edge=%0d: inc_min=%b others=%b want %b 0000",
                         e, inc_min, {inc_hour, inc_day, inc_month, inc_year}, exp);
            end
            if (e >= 5 && e <= 99) begin
                n_checks++;
                if (blank !== 1'b0) begin
                    n_fails++;
                    $display("FAIL hold_blank edge=%0d: blank=%b want 0", e, blank);
                end
            end
            if (t == 95) btn_inc = 1'b0;
        end
        n_checks++;
        if (n_min - m0 !== 6 || n_hour + n_day + n_month + n_year !== o0) begin
            n_fails++;
            $display("FAIL repeat_count: min=%0d other=%0d want 6 0",
                     n_min - m0, n_hour + n_day + n_month + n_year - o0);
        end
    endtask

    task automatic test_field_walk;
        int exp_f [5];
        logic exp_v [5];
        int tot;
        exp_f = '{2, 3, 4, 5, 0};
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tap(0);
        n_checks++;
        if (field_sel !== 3'd0 || run_en !== 1'b1 || view_date !== 1'b0) begin
            n_fails++;
            $display("FAIL exit_run: field=%0d run_en=%b view=%b want 0 1 0",
                     field_sel, run_en, view_date);
        end
        tot = n_hour + n_min + n_day + n_month + n_year;
        tap(2);
        n_checks++;
        if (view_date !== 1'b1 || n_hour + n_min + n_day + n_month + n_year !== tot) begin
            n_fails++;
            $display("FAIL run_toggle: view=%b pulses=%0d want 1 0",
                     view_date, n_hour + n_min + n_day + n_month + n_year - tot);
        end
        tap(1);
        n_checks++;
        if (field_sel !== 3'd0 || view_date !== 1'b1) begin
            n_fails++;
            $display("FAIL run_next: field=%0d view=%b want 0 1", field_sel, view_date);
        end
        tap(0);
        n_checks++;
        if (field_sel !== 3'd1 || view_date !== 1'b0 || run_en !== 1'b0) begin
            n_fails++;
            $display("FAIL hour_view: field=%0d view=%b run_en=%b want 1 0 0",
                     field_sel, view_date, run_en);
        end
        for (int i = 0; i < 5; i++) begin
            tap(1);
            n_checks++;
            if (field_sel !== exp_f[i] || view_date !== exp_v[i] || run_en !== (exp_f[i] == 0)) begin
                n_fails++;
                $display("FAIL walk step=%0d: field=%0d view=%b run_en=%b want %0d %b %b",
                         i, field_sel, view_date, run_en, exp_f[i], exp_v[i], (exp_f[i] == 0));
            end
        end
    endtask

    task automatic test_timeout;
        int d0;
        // Plain timeout from DAY.
        tap(0); tap(1);
        btn_next = 1'b1; cyc(4); btn_next = 1'b0;
        cyc(2);                        // after edge 5
        n_checks++;
        if (field_sel !== 3'd3 || view_date !== 1'b1) begin
            n_fails++;
            $display("FAIL enter_day: field=%0d view=%b want 3 1", field_sel, view_date);
        end
        cyc(1003);                     // after edge 1008: 999 idle cycles
        n_checks++;
        if (field_sel !== 3'd3) begin
            n_fails++;
            $display("FAIL tmo_999: field=%0d want 3", field_sel);
        end
        cyc(1);                        // after edge 1009
        n_checks++;
        if (field_sel !== 3'd0 || run_en !== 1'b1 || view_date !== 1'b0) begin
            n_fails++;
            $display("FAIL tmo_1000: field=%0d run_en=%b view=%b want 0 1 0",
                     field_sel, run_en, view_date);
        end
        // Inc press at cycle 900 restarts the timer.
        tap(0); tap(1);
        btn_next = 1'b1; cyc(4); btn_next = 1'b0;
        cyc(2);
        d0 = n_day;
        cyc(894);                      // after edge 899
        btn_inc = 1'b1; cyc(4); btn_inc = 1'b0;
        cyc(2);                        // after edge 905
        n_checks++;
        if (inc_day !== 1'b1) begin
            n_fails++;
            $display("FAIL tmo_inc_pulse: inc_day=%b want 1", inc_day);
        end
        cyc(104);                      // after edge 1009
        n_checks++;
        if (field_sel !== 3'd3) begin
            n_fails++;
            $display("FAIL tmo_restart: field=%0d want 3", field_sel);
        end
        cyc(899);                      // after edge 1908
        n_checks++;
        if (field_sel !== 3'd3) begin
            n_fails++;
            $display("FAIL tmo2_999: field=%0d want 3", field_sel);
        end
        cyc(1);                        // after edge 1909
        n_checks++;
        if (field_sel !== 3'd0 || run_en !== 1'b1 || n_day - d0 !== 1) begin
            n_fails++;
            $display("FAIL tmo2_1000: field=%0d run_en=%b day pulses=%0d want 0 1 1",
                     field_sel, run_en, n_day - d0);
        end
    endtask

    task automatic test_priority;
        int h0;
        tap(0);
        h0 = n_hour;
        btn_mode = 1'b1; btn_inc = 1'b1;
        cyc(4);
        btn_mode = 1'b0; btn_inc = 1'b0;
        cyc(8);
        n_checks++;
        if (field_sel !== 3'd0 || n_hour !== h0 || view_date !== 1'b0 || run_en !== 1'b1) begin
            n_fails++;
            $display("FAIL priority: field=%0d hour pulses=%0d view=%b run_en=%b want 0 0 0 1",
                     field_sel, n_hour - h0, view_date, run_en);
        end
    endtask

    task automatic test_reset_mid_repeat;
        int h0;
        tap(0);
        h0 = n_hour;
        btn_inc = 1'b1;
        cyc(66);                       // after edge 65: second repeat pulse
        n_checks++;
        if (inc_hour !== 1'b1 || n_hour - h0 !== 3) begin
            n_fails++;
            $display("FAIL pre_reset: inc_hour=%b pulses=%0d want 1 3", inc_hour, n_hour - h0);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (field_sel !== 3'd0 || run_en !== 1'b1 || view_date !== 1'b0 || blank !== 1'b0 ||
            {inc_hour, inc_min, inc_day, inc_month, inc_year} !== 5'b0) begin
            n_fails++;
            $display("FAIL async_reset: field=%0d run_en=%b view=%b blank=%b inc=%b want 0 1 0 0 00000",
                     field_sel, run_en, view_date, blank,
                     {inc_hour, inc_min, inc_day, inc_month, inc_year});
        end
        cyc(2);
        reset = 1'b0;
        h0 = n_hour;
        cyc(5);                        // after edge 4 since release
        n_checks++;
        if (view_date !== 1'b0) begin
            n_fails++;
            $display("FAIL held_early: view=%b want 0", view_date);
        end
        cyc(1);                        // after edge 5: held button is a fresh RUN press
        n_checks++;
        if (view_date !== 1'b1 || field_sel !== 3'd0 || n_hour !== h0) begin
            n_fails++;
            $display("FAIL held_press: view=%b field=%0d pulses=%0d want 1 0 0",
                     view_date, field_sel, n_hour - h0);
        end
        btn_inc = 1'b0;
        cyc(10);
    endtask

    initial begin
        test_reset();
        test_enter_set();
        test_debounce();
        test_auto_repeat();
        test_field_walk();
        test_timeout();
        test_priority();
        test_reset_mid_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
